if_fetch_unit: RTL and testbench

//  IF stage: owns the PC and issues in-order fetches to the instruction memory over a valid/ready request and

---
 rtl/if_fetch_unit.sv | 89 ++++++++
 tb/tb_if_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage owning the PC, in-order fetch queue to imem, bubble insertion and redirect flush
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] instruction_next,
    output logic [31:0] inst_address_next,
    output logic        fetch_bubble
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]           pc;
    logic [31:0]           q_addr [FIFO_DEPTH];
    logic [31:0]           q_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] q_filled;
    logic [PW-1:0]         head, tail, fill;
    logic [CW-1:0]         cnt, unfilled_cnt, drop_cnt;
    logic                  head_filled, deliver, issue, drop_resp, fill_resp, pop;
    logic                  unused_target_lsbs;

    assign unused_target_lsbs = ^redirect_target[1:0];

    // Handshake decisions and IF/ID outputs, all derived from registered state
    always_comb begin
        head_filled       = (cnt != '0) && q_filled[head];
        deliver           = rst_n && !redirect_valid && head_filled;
        imem_req_valid    = rst_n && !redirect_valid && (({1'b0, cnt} + {1'b0, drop_cnt}) < DEPTH_LIM);
        imem_req_addr     = pc;
        issue             = imem_req_valid && imem_req_ready;
        drop_resp         = imem_resp_valid && (drop_cnt != '0);
        fill_resp         = imem_resp_valid && (drop_cnt == '0) && (unfilled_cnt != '0);
        pop               = deliver && !stall;
        instruction_next  = deliver ? q_data[head] : NOP_INSTR;
        fetch_bubble      = !deliver;
        inst_address_next = !rst_n ? 32'h0 : ((cnt != '0) ? q_addr[head] : pc);
    end

    // PC, queue pointers/counters and stale-response bookkeeping; redirect flushes everything allocated
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            cnt          <= '0;
            unfilled_cnt <= '0;
            drop_cnt     <= '0;
            head         <= '0;
            tail         <= '0;
            fill         <= '0;
            q_filled     <= '0;
        end else if (redirect_valid) begin
            pc           <= {redirect_target[31:2], 2'b00};
            cnt          <= '0;
            unfilled_cnt <= '0;
            drop_cnt     <= drop_cnt + unfilled_cnt - CW'(drop_resp || fill_resp);
            head         <= '0;
            tail         <= '0;
            fill         <= '0;
            q_filled     <= '0;
        end else begin
            if (issue) pc <= pc + 32'd4;
            cnt          <= cnt + CW'(issue) - CW'(pop);
            unfilled_cnt <= unfilled_cnt + CW'(issue) - CW'(fill_resp);
            drop_cnt     <= drop_cnt - CW'(drop_resp);
            head         <= head + PW'(pop);
            tail         <= tail + PW'(issue);
            fill         <= fill + PW'(fill_resp);
            if (pop) q_filled[head] <= 1'b0;
            if (fill_resp) q_filled[fill] <= 1'b1;
        end
    end

    // Queue payload storage; validity is tracked separately so no reset is needed here
    always_ff @(posedge clk) begin
        if (issue) q_addr[tail] <= pc;
        if (fill_resp) q_data[fill] <= imem_resp_data;
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized and directed checks of the fetch unit against a queue-based reference model
module tb_if_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, stall = 1'b0, redirect_valid = 1'b0, imem_req_ready = 1'b0, imem_resp_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0, imem_resp_data = 32'h0;
    logic        imem_req_valid, fetch_bubble;
    logic [31:0] imem_req_addr, instruction_next, inst_address_next;

    if_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instruction_next(instruction_next), .inst_address_next(inst_address_next),
        .fetch_bubble(fetch_bubble)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; bit filled; } ent_t;
    typedef struct { logic [31:0] addr; int due; } req_t;

    ent_t        q[$];
    req_t        mem[$];
    logic [31:0] m_pc = RPC;
    int          m_drop = 0;
    bit          exp_req_valid;
    int          cyc = 0, last_due = 0, lat_lo = 1, lat_hi = 1;
    int          vectors = 0, miscompares = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive the memory response for this cycle, then compare every output against the model
    task automatic settle();
        logic [31:0] e_instr, e_ia;
        bit          head_ok;
        imem_resp_valid = mem.size() > 0 && mem[0].due <= cyc;
        imem_resp_data  = imem_resp_valid ? word_at(mem[0].addr) : $urandom;
        #1;
        vectors++;
        head_ok       = rst_n && !redirect_valid && q.size() > 0 && q[0].filled;
        exp_req_valid = rst_n && !redirect_valid && (q.size() + m_drop < DEPTH);
        e_instr       = head_ok ? q[0].data : NOP;
        e_ia          = !rst_n ? 32'h0 : (q.size() > 0 ? q[0].addr : m_pc);
        check("req_valid", 32'(imem_req_valid), 32'(exp_req_valid));
        if (rst_n) check("req_addr", imem_req_addr, m_pc);
        check("instruction_next", instruction_next, e_instr);
        check("inst_address_next", inst_address_next, e_ia);
        check("fetch_bubble", 32'(fetch_bubble), 32'(!head_ok));
    endtask

    // Advance the model and the memory by one clock
    task automatic advance();
        bit acc, pop, consumed;
        int unf, due;
        acc = imem_req_valid && imem_req_ready;
        if (!rst_n) begin
            m_pc = RPC;
            q.delete();
            m_drop = 0;
            mem.delete();
            last_due = cyc;
        end else begin
            if (redirect_valid) begin
                unf = 0;
                foreach (q[k]) if (!q[k].filled) unf++;
                consumed = imem_resp_valid && (m_drop > 0 || unf > 0);
                m_drop = m_drop + unf - (consumed ? 1 : 0);
                q.delete();
                m_pc = {redirect_target[31:2], 2'b00};
            end else begin
                pop = q.size() > 0 && q[0].filled && !stall;
                if (imem_resp_valid) begin
                    if (m_drop > 0) m_drop--;
                    else begin
                        for (int k = 0; k < q.size(); k++) begin
                            if (!q[k].filled) begin
                                q[k].filled = 1'b1;
                                q[k].data = imem_resp_data;
                                break;
                            end
                        end
                    end
                end
                if (pop) void'(q.pop_front());
                if (exp_req_valid && imem_req_ready) begin
                    q.push_back('{m_pc, 32'h0, 1'b0});
                    m_pc = m_pc + 32'd4;
                end
            end
            if (imem_resp_valid) void'(mem.pop_front());
            if (acc) begin
                due = cyc + int'($urandom_range(lat_hi, lat_lo));
                if (due <= last_due) due = last_due + 1;
                mem.push_back('{imem_req_addr, due});
                last_due = due;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic st, input logic rd, input logic [31:0] tgt, input logic rdy);
        rst_n = r; stall = st; redirect_valid = rd; redirect_target = tgt; imem_req_ready = rdy;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        check("reset_req_valid", 32'(imem_req_valid), 32'd0);
        check("reset_bubble", 32'(fetch_bubble), 32'd1);
        check("reset_instr", instruction_next, NOP);
        check("reset_iaddr", inst_address_next, 32'h0);
        advance();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic rand_cycles(input int n, input int p_stall, input int p_redir, input int p_ready, input int p_rst);
        for (int i = 0; i < n; i++) begin
            rst_n = int'($urandom_range(999)) >= p_rst;
            stall = int'($urandom_range(99)) < p_stall;
            redirect_valid = rst_n && (int'($urandom_range(99)) < p_redir);
            redirect_target = $urandom;
            imem_req_ready = int'($urandom_range(99)) < p_ready;
            settle();
            advance();
        end
    endtask

    task automatic expect_first(input string name, input logic [31:0] a);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            settle();
            if (!fetch_bubble) begin
                found = 1'b1;
                check({name, "_addr"}, inst_address_next, a);
                check({name, "_data"}, instruction_next, word_at(a));
            end
            advance();
        end
        check({name, "_seen"}, 32'(found), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        // Basic streaming, 1-cycle memory
        lat_lo = 1; lat_hi = 1;
        do_reset();
        settle(); check("t1_req0_addr", imem_req_addr, 32'h0); check("t1_req0_valid", 32'(imem_req_valid), 32'd1); advance();
        settle(); check("t1_req1_addr", imem_req_addr, 32'h4); check("t1_c1_bubble", 32'(fetch_bubble), 32'd1); advance();
        settle(); check("t1_out0_addr", inst_address_next, 32'h0); check("t1_out0_data", instruction_next, word_at(32'h0));
        check("t1_out0_bubble", 32'(fetch_bubble), 32'd0); advance();
        settle(); check("t1_out1_addr", inst_address_next, 32'h4); advance();
        rand_cycles(40, 0, 0, 100, 0);
        // Long latency
        lat_lo = 3; lat_hi = 3;
        rand_cycles(60, 0, 0, 100, 0);
        // Stall with full queue
        lat_lo = 1; lat_hi = 1;
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin settle(); advance(); end
        for (int i = 0; i < 4; i++) begin
            settle();
            check("t3_req_blocked", 32'(imem_req_valid), 32'd0);
            check("t3_head_addr", inst_address_next, 32'h0);
            check("t3_head_data", instruction_next, word_at(32'h0));
            advance();
        end
        stall = 1'b0;
        settle(); check("t3_release_addr", inst_address_next, 32'h0); advance();
        settle(); check("t3_resume_addr", inst_address_next, 32'h4); check("t3_resume_bubble", 32'(fetch_bubble), 32'd0); advance();
        rand_cycles(20, 0, 0, 100, 0);
        // Redirect with two unfilled in flight
        lat_lo = 3; lat_hi = 3;
        do_reset();
        settle(); advance();
        settle(); advance();
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0102, 1'b1);
        settle(); check("t4_redirect_bubble", 32'(fetch_bubble), 32'd1); advance();
        redirect_valid = 1'b0;
        settle(); check("t4_pc", imem_req_addr, 32'h100); check("t4_blocked_by_drops", 32'(imem_req_valid), 32'd0); advance();
        expect_first("t4_first", 32'h100);
        // Redirect with simultaneous response and stall
        lat_lo = 2; lat_hi = 2;
        do_reset();
        settle(); advance();
        settle(); advance();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_2000, 1'b1);
        settle(); check("t5_bubble", 32'(fetch_bubble), 32'd1); advance();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        settle(); check("t5_req_valid", 32'(imem_req_valid), 32'd1); check("t5_req_addr", imem_req_addr, 32'h2000); advance();
        expect_first("t5_first", 32'h2000);
        // PC wrap and mid-burst reset
        lat_lo = 1; lat_hi = 1;
        do_reset();
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
        settle(); advance();
        redirect_valid = 1'b0;
        settle(); check("t6_top_addr", imem_req_addr, 32'hFFFF_FFFC); check("t6_top_valid", 32'(imem_req_valid), 32'd1); advance();
        settle(); check("t6_wrap_addr", imem_req_addr, 32'h0); advance();
        rand_cycles(10, 10, 0, 100, 0);
        rst_n = 1'b0;
        settle(); advance();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        settle(); check("t6_reset_pc", imem_req_addr, RPC); check("t6_reset_bubble", 32'(fetch_bubble), 32'd1);
        check("t6_reset_iaddr", inst_address_next, RPC); advance();
        expect_first("t6_first", RPC);
        // Randomized mix of everything
        lat_lo = 1; lat_hi = 4;
        rand_cycles(3000, 20, 5, 75, 3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
